// File: rtl/regfile_writeback_queue.sv
// Write-side front end for the register file: round-robin merge of ALU and memory
// results into a small FIFO that drains one write per cycle, plus a RAW pending mask.
module regfile_writeback_queue #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      flush,
  input  logic                      alu_valid,
  input  logic [ADDR_W-1:0]         alu_addr,
  input  logic [DATA_W-1:0]         alu_data,
  output logic                      alu_ready,
  input  logic                      mem_valid,
  input  logic [ADDR_W-1:0]         mem_addr,
  input  logic [DATA_W-1:0]         mem_data,
  output logic                      mem_ready,
  output logic [ADDR_W-1:0]         c,
  output logic [DATA_W-1:0]         data,
  output logic                      load,
  output logic [(1<<ADDR_W)-1:0]    pending,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {GRANT_ALU, GRANT_MEM} grant_e;

  grant_e              last_grant;
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;
  logic [ADDR_W-1:0]   addr_q [DEPTH];
  logic [DATA_W-1:0]   data_q [DEPTH];

  logic                space;
  logic                pick_mem;
  logic                enq;
  logic                pop;
  logic [ADDR_W-1:0]   enq_addr;
  logic [DATA_W-1:0]   enq_data;
  logic [PTR_W-1:0]    idx;

  // Contention goes to whichever source did not win the last actual enqueue.
  always_comb begin
    space     = count < CNT_W'(DEPTH);
    pick_mem  = mem_valid & (~alu_valid | (last_grant == GRANT_ALU));
    enq       = space & ~flush & (alu_valid | mem_valid);
    alu_ready = enq & ~pick_mem;
    mem_ready = enq & pick_mem;
    enq_addr  = pick_mem ? mem_addr : alu_addr;
    enq_data  = pick_mem ? mem_data : alu_data;
    pop       = count != '0;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      last_grant <= GRANT_ALU;
    end else begin
      if (flush) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        count  <= count + CNT_W'(enq) - CNT_W'(pop);
        rd_ptr <= rd_ptr + PTR_W'(pop);
        wr_ptr <= wr_ptr + PTR_W'(enq);
      end
      if (enq) last_grant <= pick_mem ? GRANT_MEM : GRANT_ALU;
    end
  end

  // Storage needs no reset: every output is gated by count.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[wr_ptr] <= enq_addr;
      data_q[wr_ptr] <= enq_data;
    end
  end

  always_comb begin
    load    = count != '0;
    c       = load ? addr_q[rd_ptr] : '0;
    data    = load ? data_q[rd_ptr] : '0;
    pending = '0;
    idx     = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if (CNT_W'(k) < count) pending[addr_q[idx]] = 1'b1;
    end
  end

endmodule
